lcd_frame_sequencer: RTL and testbench
======================================

LCD_FRAME_SEQUENCER -- requirements
Module: lcd_frame_sequencer

Interface
REQ-001 Parameter IMG_W, default 28: source image width in pixels.
REQ-002 Parameter IMG_H, default 28: source image height in pixels.
REQ-003 Parameter SCALE, default 5: integer upscale factor applied to both axes, with 1 <= SCALE <= 15.
REQ-004 Parameter ADDR_W, default 10: source memory address width, with 2^ADDR_W >= IMG_W*IMG_H.
REQ-005 Parameter FG_COLOR, default 16'hFFFF: RGB565 colour sent for source bit 1.
REQ-006 Parameter BG_COLOR, default 16'h0000: RGB565 colour sent for source bit 0.
REQ-007 Ports, as name, direction, width, meaning:
- clk, in, 1, clock.
- reset, in, 1, synchronous, active-high.
- start, in, 1, frame request pulse.
- busy, out, 1, frame in progress.
- frame_done, out, 1, one-cycle pulse when the last pixel completes.
- aborted, out, 1, one-cycle pulse when a frame is dropped.
- mem_rd, out, 1, source memory read strobe.
- mem_addr, out, ADDR_W, source pixel address, row-major (y*IMG_W + x).
- mem_rdata, in, 1, source pixel, valid on the cycle after mem_rd.
- drv_initialized, in, 1, LCD driver init complete.
- drv_done, in, 1, LCD driver pixel-write-complete level.
- drv_en, out, 1, LCD driver enable.
- drv_print, out, 1, LCD driver pixel request.
- drv_pixel, out, 16, RGB565 pixel to the driver.

Function
REQ-008 States SHALL be IDLE, FETCH, LOAD, ISSUE, WAIT_ACK, WAIT_DONE and ADVANCE.
REQ-009 IDLE SHALL go to FETCH on start=1 with drv_initialized=1; start is ignored in every other case, including while busy.
REQ-010 On leaving IDLE, the output counters SHALL be cleared: ox=0, oy=0 (width 9 bits each), sub-counters sx=0, sy=0, and source indices x=0, y=0.
REQ-011 FETCH SHALL assert mem_rd for exactly one cycle with mem_addr=y*IMG_W+x, then go to LOAD.
REQ-012 LOAD SHALL register drv_pixel = mem_rdata ? FG_COLOR : BG_COLOR, then go to ISSUE.
REQ-013 ISSUE and WAIT_ACK SHALL assert drv_print=1 with drv_pixel held stable.
REQ-014 ISSUE SHALL go to WAIT_ACK on the next cycle.
REQ-015 WAIT_ACK SHALL stay until drv_done=0 is sampled (write accepted), then go to WAIT_DONE.
REQ-016 WAIT_DONE SHALL drive drv_print=0 and stay until drv_done=1, then go to ADVANCE.
REQ-017 drv_print SHALL therefore be low for at least one cycle between consecutive pixels.
REQ-018 ADVANCE SHALL step the counters in row-major order: sx increments; when sx wraps at SCALE, sx=0 and x increments; when x wraps at IMG_W, x=0 and the row advances.
REQ-019 On a row advance, sy increments; when sy wraps at SCALE, sy=0 and y increments.
REQ-020 When the pixel just completed is x=IMG_W-1, y=IMG_H-1, sx=SCALE-1, sy=SCALE-1, the block SHALL pulse frame_done and go to IDLE.
REQ-021 Otherwise, ADVANCE SHALL go to FETCH when sx wrapped or the row advanced (source pixel changed).
REQ-022 Otherwise, ADVANCE SHALL go straight to ISSUE and reuse drv_pixel, with no memory read.
REQ-023 Each frame SHALL produce exactly IMG_W*IMG_H*SCALE^2 drv_print acceptances and exactly IMG_W*IMG_H*SCALE mem_rd pulses.
REQ-024 busy SHALL be 1 in every state except IDLE; drv_en SHALL equal busy.
REQ-025 If drv_initialized=0 is sampled in any non-IDLE state, the block SHALL pulse aborted, drop drv_print the same cycle, go to IDLE, and not pulse frame_done.
REQ-026 If abort and the final ADVANCE coincide, abort SHALL take priority.
REQ-027 A start arriving in the same cycle that frame_done pulses SHALL be ignored; a new frame requires start while in IDLE.
REQ-028 drv_pixel SHALL change only in LOAD; mem_addr SHALL change only in FETCH.

Reset
REQ-029 While reset=1 at a clock edge, the block SHALL enter IDLE.
REQ-030 Reset values SHALL be: busy=0, frame_done=0, aborted=0, mem_rd=0, mem_addr=0, drv_en=0, drv_print=0, drv_pixel=BG_COLOR, and all counters 0.
REQ-031 Reset mid-frame SHALL discard the frame silently, with no frame_done and no aborted pulse.

Verification
REQ-032 IMG_W=2, IMG_H=2, SCALE=2, memory 1,0,0,1, driver model (done drops 1 cycle after print, rises 1 cycle later) -> 16 prints with sequence F,F,B,B, F,F,B,B, B,B,F,F, B,B,F,F (F=FFFF, B=0000); 8 mem_rd pulses; one frame_done.
REQ-033 start with drv_initialized=0 -> busy stays 0, no mem_rd, no drv_print.
REQ-034 Same setup as REQ-032, start pulsed again mid-frame -> still exactly 16 prints and one frame_done.
REQ-035 Driver model holds drv_done=1 for 20 cycles after print -> drv_print and drv_pixel stay stable in WAIT_ACK, and the next pixel starts only after the drv_done 0->1 sequence.
REQ-036 drv_initialized dropped after the 5th print -> aborted pulses once, busy=0 next cycle, no frame_done; a new start with drv_initialized=1 restarts at mem_addr=0.
REQ-037 reset asserted in WAIT_DONE -> all REQ-030 reset values on the next cycle, no frame_done and no aborted pulse.

Source files
------------

// File: rtl/lcd_frame_sequencer.sv
// Streams a 1-bit source image to an LCD pixel driver, upscaled by SCALE on both axes.
// Latency: first drv_print 3 cycles after start; each pixel costs ISSUE/ACK/DONE/ADVANCE plus FETCH/LOAD on a new source pixel.
// Backpressure: the driver paces every pixel through drv_done (drop = accepted, rise = complete); dropping drv_initialized aborts the frame.
module lcd_frame_sequencer #(
   parameter int          IMG_W    = 28,
   parameter int          IMG_H    = 28,
   parameter int          SCALE    = 5,
   parameter int          ADDR_W   = 10,
   parameter logic [15:0] FG_COLOR = 16'hFFFF,
   parameter logic [15:0] BG_COLOR = 16'h0000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              busy,
   output logic              frame_done,
   output logic              aborted,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_rdata,
   input  logic              drv_initialized,
   input  logic              drv_done,
   output logic              drv_en,
   output logic              drv_print,
   output logic [15:0]       drv_pixel
);

   // Counter widths; a 1-pixel axis still needs a 1-bit index.
   localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

   // Wrap points for the source, sub-pixel and output counters.
   localparam logic [3:0]        S_LAST    = 4'(SCALE - 1);
   localparam logic [XW-1:0]     X_LAST    = XW'(IMG_W - 1);
   localparam logic [YW-1:0]     Y_LAST    = YW'(IMG_H - 1);
   localparam logic [8:0]        OX_LAST   = 9'(IMG_W * SCALE - 1);
   localparam logic [8:0]        OY_LAST   = 9'(IMG_H * SCALE - 1);
   localparam logic [ADDR_W-1:0] ROW_PITCH = ADDR_W'(IMG_W);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_FETCH     = 3'd1,
      S_LOAD      = 3'd2,
      S_ISSUE     = 3'd3,
      S_WAIT_ACK  = 3'd4,
      S_WAIT_DONE = 3'd5,
      S_ADVANCE   = 3'd6
   } state_t;

   state_t r_state;
   state_t w_next_state;

   // Sub-pixel repeat counters, source indices and output-space coordinates.
   logic [3:0]        r_sx;
   logic [3:0]        r_sy;
   logic [XW-1:0]     r_x;
   logic [YW-1:0]     r_y;
   logic [8:0]        r_ox;
   logic [8:0]        r_oy;

   // Registered driver pixel and the address presented on the last fetch.
   logic [15:0]       r_pixel;
   logic [ADDR_W-1:0] r_mem_addr;

   logic              w_launch;
   logic              w_step;
   logic              w_sx_wrap;
   logic              w_x_wrap;
   logic              w_row_adv;
   logic              w_sy_wrap;
   logic              w_last;
   logic [ADDR_W-1:0] w_src_addr;

   // A frame only launches from IDLE with an initialised driver.
   assign w_launch   = (r_state == S_IDLE) && start && drv_initialized;
   // Counters advance only on a completed pixel that is not being aborted.
   assign w_step     = (r_state == S_ADVANCE) && drv_initialized;

   assign w_sx_wrap  = (r_sx == S_LAST);
   assign w_x_wrap   = (r_x == X_LAST);
   assign w_row_adv  = w_sx_wrap && w_x_wrap;
   assign w_sy_wrap  = (r_sy == S_LAST);
   // Last output pixel of the frame: bottom-right corner in output space.
   assign w_last     = (r_ox == OX_LAST) && (r_oy == OY_LAST);

   assign w_src_addr = (ADDR_W'(r_y) * ROW_PITCH) + ADDR_W'(r_x);

   // State register with synchronous reset back to IDLE.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic; losing the driver in any active state wins over everything else.
   always_comb begin
      w_next_state = r_state;
      if ((r_state != S_IDLE) && !drv_initialized) begin
         w_next_state = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start && drv_initialized) begin
                  w_next_state = S_FETCH;
               end
            end
            S_FETCH: begin
               w_next_state = S_LOAD;
            end
            S_LOAD: begin
               w_next_state = S_ISSUE;
            end
            S_ISSUE: begin
               w_next_state = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
               if (!drv_done) begin
                  w_next_state = S_WAIT_DONE;
               end
            end
            S_WAIT_DONE: begin
               if (drv_done) begin
                  w_next_state = S_ADVANCE;
               end
            end
            S_ADVANCE: begin
               if (w_last) begin
                  w_next_state = S_IDLE;
               end else if (w_sx_wrap) begin
                  // Moving to a different source pixel (covers row advance too).
                  w_next_state = S_FETCH;
               end else begin
                  // Same source pixel repeated horizontally: reuse drv_pixel.
                  w_next_state = S_ISSUE;
               end
            end
            default: begin
               w_next_state = S_IDLE;
            end
         endcase
      end
   end

   // Output decode; pulses are masked during reset so a reset never reports a frame event.
   always_comb begin
      busy       = (r_state != S_IDLE);
      drv_en     = (r_state != S_IDLE);
      mem_rd     = (r_state == S_FETCH);
      drv_print  = ((r_state == S_ISSUE) || (r_state == S_WAIT_ACK)) && drv_initialized;
      aborted    = (r_state != S_IDLE) && !drv_initialized && !reset;
      frame_done = (r_state == S_ADVANCE) && w_last && drv_initialized && !reset;
      // The fetch address appears in FETCH itself and is held afterwards.
      mem_addr   = (r_state == S_FETCH) ? w_src_addr : r_mem_addr;
      drv_pixel  = r_pixel;
   end

   // Raster counters: cleared on launch, stepped row-major once per completed pixel.
   always_ff @(posedge clk) begin
      if (reset || w_launch) begin
         r_sx <= '0;
         r_sy <= '0;
         r_x  <= '0;
         r_y  <= '0;
         r_ox <= '0;
         r_oy <= '0;
      end else if (w_step) begin
         r_sx <= w_sx_wrap ? 4'd0 : (r_sx + 4'd1);
         if (w_sx_wrap) begin
            r_x <= w_x_wrap ? '0 : (r_x + XW'(1));
         end
         if (w_row_adv) begin
            r_sy <= w_sy_wrap ? 4'd0 : (r_sy + 4'd1);
            if (w_sy_wrap) begin
               r_y <= (r_y == Y_LAST) ? '0 : (r_y + YW'(1));
            end
         end
         r_ox <= w_row_adv ? 9'd0 : (r_ox + 9'd1);
         if (w_row_adv) begin
            r_oy <= w_last ? 9'd0 : (r_oy + 9'd1);
         end
      end
   end

   // Pixel colour is captured only in LOAD, one cycle after the memory read.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pixel <= BG_COLOR;
      end else if ((r_state == S_LOAD) && drv_initialized) begin
         r_pixel <= mem_rdata ? FG_COLOR : BG_COLOR;
      end
   end

   // Hold the fetch address so mem_addr only moves when a new fetch happens.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_mem_addr <= '0;
      end else if (r_state == S_FETCH) begin
         r_mem_addr <= w_src_addr;
      end
   end

endmodule

// File: tb/tb_lcd_frame_sequencer.sv
// Bench for lcd_frame_sequencer on a 2x2 image at scale 2 with a reactive driver/memory model.
// Frames are table-driven; abort, reset and start-timing corners are hand sequences.
// Inputs change 1-2 time units after the rising edge, outputs are observed on the falling edge.
module tb_lcd_frame_sequencer;

   localparam logic [15:0] FG = 16'hFFFF;
   localparam logic [15:0] BG = 16'h0000;

   logic        clk             = 1'b0;
   logic        reset           = 1'b1;
   logic        start           = 1'b0;
   logic        busy;
   logic        frame_done;
   logic        aborted;
   logic        mem_rd;
   logic [1:0]  mem_addr;
   logic        mem_rdata       = 1'b0;
   logic        drv_initialized = 1'b1;
   logic        drv_done        = 1'b1;
   logic        drv_en;
   logic        drv_print;
   logic [15:0] drv_pixel;

   lcd_frame_sequencer #(
      .IMG_W(2), .IMG_H(2), .SCALE(2), .ADDR_W(2),
      .FG_COLOR(16'hFFFF), .BG_COLOR(16'h0000)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .busy(busy),
      .frame_done(frame_done), .aborted(aborted), .mem_rd(mem_rd),
      .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .drv_initialized(drv_initialized), .drv_done(drv_done),
      .drv_en(drv_en), .drv_print(drv_print), .drv_pixel(drv_pixel)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Model configuration (written by the main sequence only).
   logic [3:0] img_cfg     = 4'b1001;
   int         hold_cfg    = 1;
   int         abort_after = 0;
   logic       tb_init     = 1'b1;

   // Running observation counters (written by the model only).
   int n_print, n_rd, n_done, n_abort, n_busy, n_print_hi;
   int n_unstable, n_proto, n_start_at_done, n_abort_print;
   logic       pix_log [256];
   logic [1:0] rd_log  [256];

   // Baselines taken at the start of each scenario.
   int b_print, b_rd, b_done, b_abort, b_busy, b_print_hi;
   int b_unstable, b_proto, b_sad, b_abp;

   typedef struct {
      logic [3:0]  img;
      int          hold;
      logic        mid_start;
      logic        end_start;
      logic [15:0] exp_seq;
      int          exp_prints;
      int          exp_rd;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic snap();
      b_print = n_print; b_rd = n_rd; b_done = n_done; b_abort = n_abort;
      b_busy = n_busy; b_print_hi = n_print_hi; b_unstable = n_unstable;
      b_proto = n_proto; b_sad = n_start_at_done; b_abp = n_abort_print;
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   task automatic check_idle(input string tag);
      chk({tag, ".busy"},       32'(busy),       32'd0);
      chk({tag, ".frame_done"}, 32'(frame_done), 32'd0);
      chk({tag, ".aborted"},    32'(aborted),    32'd0);
      chk({tag, ".mem_rd"},     32'(mem_rd),     32'd0);
      chk({tag, ".mem_addr"},   32'(mem_addr),   32'd0);
      chk({tag, ".drv_en"},     32'(drv_en),     32'd0);
      chk({tag, ".drv_print"},  32'(drv_print),  32'd0);
      chk({tag, ".drv_pixel"},  32'(drv_pixel),  32'(BG));
   endtask

   task automatic run_vec(input int i, input string tag);
      vec_t        v;
      int          cyc;
      int          end_cnt;
      logic        mid_done;
      logic [15:0] got;
      v        = vecs[i];
      img_cfg  = v.img;
      hold_cfg = v.hold;
      snap();
      pulse_start();
      cyc = 0; end_cnt = 0; mid_done = 1'b0;
      while ((n_done == b_done) && (n_abort == b_abort) && (cyc < 3000)) begin
         start = 1'b0;
         if (v.mid_start && !mid_done && (n_print - b_print >= 6)) begin
            start    = 1'b1;
            mid_done = 1'b1;
         end
         if (v.end_start) begin
            if (n_print - b_print >= 16) end_cnt++;
            if (end_cnt == 3) start = 1'b1;
         end
         tick(1);
         cyc++;
      end
      start = 1'b0;
      tick(6);
      for (int k = 0; k < 16; k++) begin
         got[k] = ((b_print + k) < 256) ? pix_log[b_print + k] : 1'bx;
      end
      chk({tag, ".prints"},   32'(n_print - b_print),       32'(v.exp_prints));
      chk({tag, ".mem_rds"},  32'(n_rd - b_rd),             32'(v.exp_rd));
      chk({tag, ".done"},     32'(n_done - b_done),         32'd1);
      chk({tag, ".aborted"},  32'(n_abort - b_abort),       32'd0);
      chk({tag, ".seq"},      32'(got),                     32'(v.exp_seq));
      chk({tag, ".stable"},   32'(n_unstable - b_unstable), 32'd0);
      chk({tag, ".handshk"},  32'(n_proto - b_proto),       32'd0);
      chk({tag, ".addr0"},    32'(rd_log[b_rd]),            32'd0);
      chk({tag, ".idle"},     32'(busy),                    32'd0);
      if (v.end_start) begin
         chk({tag, ".start_at_done"}, 32'(n_start_at_done - b_sad), 32'd1);
      end
   endtask

   // Driver + memory model: observe on the falling edge, respond just after the rising edge.
   initial begin : model
      logic        nxt_done;
      logic        nxt_rdata;
      int          hold_cnt;
      logic        acc_flag;
      logic        prev_print;
      logic [15:0] prev_pixel;
      hold_cnt = 0; acc_flag = 1'b0; prev_print = 1'b0; prev_pixel = '0;
      forever begin
         @(negedge clk);
         if (busy)       n_busy++;
         if (drv_print)  n_print_hi++;
         if (frame_done) n_done++;
         if (aborted)    n_abort++;
         if (aborted && drv_print) n_abort_print++;
         if (start && frame_done)  n_start_at_done++;
         if (drv_print && prev_print && (drv_pixel !== prev_pixel)) n_unstable++;
         if (drv_print && !prev_print && !drv_done) n_proto++;
         if (!drv_print) acc_flag = 1'b0;
         else if (acc_flag && drv_done) n_proto++;
         // Source memory: data valid during the cycle after the read strobe.
         nxt_rdata = $urandom_range(0, 1) != 0;
         if (mem_rd) begin
            nxt_rdata = img_cfg[mem_addr];
            if (n_rd < 256) rd_log[n_rd] = mem_addr;
            n_rd++;
         end
         // Driver: accept after hold_cfg cycles of print, complete one cycle later.
         nxt_done = drv_done;
         if (!drv_done) begin
            nxt_done = 1'b1;
         end else if (drv_print) begin
            hold_cnt++;
            if (hold_cnt >= hold_cfg) begin
               nxt_done = 1'b0;
               hold_cnt = 0;
               acc_flag = 1'b1;
               if ((drv_pixel !== FG) && (drv_pixel !== BG)) n_unstable++;
               if (n_print < 256) pix_log[n_print] = (drv_pixel === FG);
               n_print++;
            end
         end else begin
            hold_cnt = 0;
         end
         prev_print = drv_print;
         prev_pixel = drv_pixel;
         @(posedge clk);
         #1;
         drv_done        = nxt_done;
         mem_rdata       = nxt_rdata;
         drv_initialized = tb_init && !((abort_after != 0) && (n_print >= abort_after));
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
      $fatal(1, "watchdog");
   end

   initial begin : main
      int cyc;
      // {img, hold, mid_start, end_start, expected F/B sequence, prints, mem reads}
      vecs[0] = '{4'b1001, 1,  1'b0, 1'b0, 16'hCC33, 16, 8};
      vecs[1] = '{4'b0000, 1,  1'b0, 1'b0, 16'h0000, 16, 8};
      vecs[2] = '{4'b0110, 3,  1'b0, 1'b0, 16'h33CC, 16, 8};
      vecs[3] = '{4'b0011, 20, 1'b0, 1'b0, 16'h00FF, 16, 8};
      vecs[4] = '{4'b1001, 1,  1'b1, 1'b0, 16'hCC33, 16, 8};
      vecs[5] = '{4'b1001, 2,  1'b0, 1'b1, 16'hCC33, 16, 8};

      // Power-on reset.
      reset = 1'b1;
      tick(3);
      reset = 1'b0;
      check_idle("por");

      // Start while the driver is not initialised is ignored.
      tb_init = 1'b0;
      tick(3);
      snap();
      pulse_start();
      tick(10);
      chk("noinit.busy",  32'(n_busy - b_busy),         32'd0);
      chk("noinit.rd",    32'(n_rd - b_rd),             32'd0);
      chk("noinit.print", 32'(n_print_hi - b_print_hi), 32'd0);
      tb_init = 1'b1;
      tick(3);

      // Table-driven frames.
      for (int i = 0; i < 6; i++) begin
         run_vec(i, $sformatf("vec%0d", i));
      end

      // Driver loses initialisation after the 5th accepted pixel.
      img_cfg  = 4'b1001;
      hold_cfg = 1;
      snap();
      abort_after = n_print + 5;
      pulse_start();
      cyc = 0;
      while ((n_abort == b_abort) && (cyc < 500)) begin
         tick(1);
         cyc++;
      end
      chk("abort.busy_next", 32'(busy), 32'd0);
      tick(5);
      chk("abort.pulses",    32'(n_abort - b_abort),     32'd1);
      chk("abort.done",      32'(n_done - b_done),       32'd0);
      chk("abort.prints",    32'(n_print - b_print),     32'd5);
      chk("abort.print_low", 32'(n_abort_print - b_abp), 32'd0);
      abort_after = 0;
      tick(3);
      run_vec(0, "restart");

      // Reset while waiting for the 3rd pixel to complete.
      img_cfg  = 4'b0110;
      hold_cfg = 1;
      snap();
      pulse_start();
      cyc = 0;
      while ((n_print - b_print < 3) && (cyc < 500)) begin
         tick(1);
         cyc++;
      end
      tick(1);
      chk("rst.in_wait_done", 32'({busy, drv_print}), 32'b10);
      reset = 1'b1;
      tick(1);
      check_idle("rst");
      reset = 1'b0;
      tick(5);
      chk("rst.done",  32'(n_done - b_done),   32'd0);
      chk("rst.abort", 32'(n_abort - b_abort), 32'd0);
      run_vec(2, "after_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
